// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide engine: iterative MULT/MULTU/DIV/DIVU, HI/LO registers and moves.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier, MULT/MULTU go straight to FIX.
module exe_muldiv_unit #(
  parameter logic [5:0] OP_MULT  = 6'h18,
  parameter logic [5:0] OP_MULTU = 6'h19,
  parameter logic [5:0] OP_DIV   = 6'h1A,
  parameter logic [5:0] OP_DIVU  = 6'h1B,
  parameter logic [5:0] OP_MFHI  = 6'h10,
  parameter logic [5:0] OP_MTHI  = 6'h11,
  parameter logic [5:0] OP_MFLO  = 6'h12,
  parameter logic [5:0] OP_MTLO  = 6'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  EXE_alu_op,
  input  logic [31:0] EXE_opA,
  input  logic [31:0] EXE_opB,
  input  logic        exe_kill,
  output logic        muldiv_stall,
  output logic        muldiv_busy,
  output logic [31:0] EXE_hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;   // mul: {partial, multiplier}; div: quotient in [31:0]
  logic [31:0] rem_q, rem_d;
  logic        is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic        is_mul, is_divop, is_md, is_hilo, signed_op, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, rem_sh;
  logic        rem_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  always_comb begin
    is_mul    = (EXE_alu_op == OP_MULT) || (EXE_alu_op == OP_MULTU);
    is_divop  = (EXE_alu_op == OP_DIV) || (EXE_alu_op == OP_DIVU);
    is_md     = is_mul || is_divop;
    is_hilo   = is_md || (EXE_alu_op == OP_MFHI) || (EXE_alu_op == OP_MTHI) ||
                (EXE_alu_op == OP_MFLO) || (EXE_alu_op == OP_MTLO);
    signed_op = (EXE_alu_op == OP_MULT) || (EXE_alu_op == OP_DIV);
    a_neg     = signed_op & EXE_opA[31];
    b_neg     = signed_op & EXE_opB[31];
    a_abs     = a_neg ? (~EXE_opA + 32'd1) : EXE_opA;
    b_abs     = b_neg ? (~EXE_opB + 32'd1) : EXE_opB;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {32'd0, a_abs} * {32'd0, b_abs};
`endif
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    rem_sh    = {rem_q, acc_q[31]};
    rem_ge    = rem_sh >= {1'b0, opb_q};
    prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (!exe_kill) begin
          if (is_md) begin
            is_div_d  = is_divop;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            count_d   = 5'd0;
            rem_d     = 32'd0;
            opb_d     = is_mul ? a_abs : b_abs;
            acc_d     = is_mul ? {32'd0, b_abs} : {32'd0, a_abs};
            state_d   = StRun;
            if (is_divop && (EXE_opB == 32'd0)) begin
              // Divide by zero: FIX writes lo=all-ones, hi=raw dividend, no sign fixup.
              acc_d     = {32'd0, 32'hFFFF_FFFF};
              rem_d     = EXE_opA;
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = StFix;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul) begin
              acc_d   = fast_prod;
              state_d = StFix;
            end
`endif
          end else if (EXE_alu_op == OP_MTHI) begin
            hi_d = EXE_opA;
          end else if (EXE_alu_op == OP_MTLO) begin
            lo_d = EXE_opA;
          end
        end
      end
      StRun: begin
        if (is_div_q) begin
          rem_d = rem_ge ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
          acc_d = {32'd0, acc_q[30:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign muldiv_busy    = (state_q != StIdle);
  assign muldiv_stall   = muldiv_busy & is_hilo & ~exe_kill;
  assign EXE_hilo_rdata = (EXE_alu_op == OP_MFHI) ? hi_q :
                          (EXE_alu_op == OP_MFLO) ? lo_q : 32'd0;
  assign hi             = hi_q;
  assign lo             = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: results are checked when busy falls.
// Honours MULDIV_FAST_MUL_EN for the expected multiply busy length.
module tb_exe_muldiv_unit;

  localparam logic [5:0] NOP = 6'h00, ADD = 6'h20;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulCyc = 1;
`else
  localparam int MulCyc = 33;
`endif
  localparam int DivCyc = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic        kill;
  logic        stall, busy;
  logic [31:0] rdata, hi, lo;

  exe_muldiv_unit dut (
    .clk           (clk),
    .rst           (rst),
    .EXE_alu_op    (alu_op),
    .EXE_opA       (op_a),
    .EXE_opB       (op_b),
    .exe_kill      (kill),
    .muldiv_stall  (stall),
    .muldiv_busy   (busy),
    .EXE_hilo_rdata(rdata),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge presents a result; pop and compare.
  initial begin : monitor
    bit   prev = 1'b0;
    int   cyc  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev = 1'b0;
        cyc  = 0;
      end else if (busy) begin
        prev = 1'b1;
        cyc++;
      end else begin
        if (prev) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got result hi=%h lo=%h expected none", hi, lo);
          end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
          end
        end
        prev = 1'b0;
        cyc  = 0;
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic k);
    @(negedge clk);
    alu_op = op;
    op_a   = a;
    op_b   = b;
    kill   = k;
    @(posedge clk);
    #1;
    alu_op = NOP;
    kill   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0 within 200 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int cyc);
    sb.push_back('{name, ehi, elo, cyc});
    issue(op, a, b, 1'b0);
    wait_idle(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1; alu_op = MFLO; op_a = '0; op_b = '0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    alu_op = MFHI;
    #1 check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0; alu_op = NOP;

    run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulCyc);
    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MulCyc);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivCyc);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DivCyc);
    run_op("divu_zero", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DivCyc);

    // Dependent MFLO right behind a MULT: 7 * -3 = -21.
    sb.push_back('{"mult_stall", 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulCyc});
    @(negedge clk);
    alu_op = MULT; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    alu_op = MFLO;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(MulCyc));
    check("stall_rdata", rdata, 32'hFFFF_FFEB);
    alu_op = NOP;

    // Non-HI/LO op while busy never stalls.
    sb.push_back('{"multu_add", 32'd0, 32'd30, MulCyc});
    issue(MULTU, 32'd5, 32'd6, 1'b0);
    alu_op = ADD;
    @(negedge clk);
    check("add_stall", {31'd0, stall}, 32'd0);
    check("add_busy", {31'd0, busy}, 32'd1);
    alu_op = NOP;
    wait_idle("multu_add");

    issue(MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("mthi_killed", hi, 32'd0);
    issue(MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mthi", hi, 32'hDEAD_BEEF);
    issue(MTLO, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo", lo, 32'h1234_5678);
    alu_op = MFHI;
    #1 check("mfhi_rdata", rdata, 32'hDEAD_BEEF);
    alu_op = MFLO;
    #1 check("mflo_rdata", rdata, 32'h1234_5678);
    alu_op = ADD;
    #1 check("add_rdata", rdata, 32'd0);
    alu_op = NOP;
    issue(MULT, 32'd3, 32'd3, 1'b1);
    @(negedge clk);
    check("mult_killed_busy", {31'd0, busy}, 32'd0);
    check("mult_killed_lo", lo, 32'h1234_5678);

    // Abort a divide at RUN count 10 with reset.
    issue(DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst    = 1'b1;
    alu_op = MFLO;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    alu_op = NOP;
    run_op("multu_after_rst", MULTU, 32'd5, 32'd6, 32'd0, 32'd30, MulCyc);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
